// File: rtl/order_packetizer_if.sv
// Byte-wide valid/ready order stream between the packetizer and the exchange-side link.
interface order_packetizer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/order_packetizer.sv
// Turns buy/sell decisions into 4-byte order packets (header, side/seq, price, checksum),
// tracking net position against a limit and holding off new decisions for a cooldown.
module order_packetizer #(
    parameter logic signed [7:0] MAX_POS  = 8'sd4,
    parameter int unsigned       COOLDOWN = 8,
    parameter logic [7:0]        HEADER   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    buy_signal,
    input  logic                    sell_signal,
    input  logic [7:0]              price,
    order_packetizer_if.master      tx,
    output logic signed [7:0]       position,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_COOL} state_t;

    localparam logic signed [7:0] NEG_MAX = -MAX_POS;
    localparam logic [7:0]        CD_LOAD = 8'(COOLDOWN);

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [6:0]  seq;
    logic [7:0]  cd_cnt;
    logic        side;
    logic [7:0]  cap_price;

    logic        take_buy;
    logic        take_sell;
    logic        drop_evt;
    logic        last_fire;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        take_buy  = (state == ST_IDLE) && buy_signal && !sell_signal && (position < MAX_POS);
        take_sell = (state == ST_IDLE) && sell_signal && !buy_signal && (position > NEG_MAX);
        // In IDLE only conflicts and limit blocks count; any request while busy is lost.
        if (state == ST_IDLE)
            drop_evt = (buy_signal || sell_signal) && !take_buy && !take_sell;
        else
            drop_evt = buy_signal || sell_signal;
        last_fire = (state == ST_SEND) && tx.tx_ready && (idx == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (take_buy || take_sell) state_next = ST_SEND;
            ST_SEND: if (last_fire) state_next = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
            ST_COOL: if (cd_cnt <= 8'd1) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx.tx_valid = (state == ST_SEND);
        tx.tx_last  = (state == ST_SEND) && (idx == 2'd3);
        busy        = (state != ST_IDLE);
        tx.tx_data  = 8'h00;
        if (state == ST_SEND) begin
            case (idx)
                2'd0:    tx.tx_data = HEADER;
                2'd1:    tx.tx_data = {side, seq};
                2'd2:    tx.tx_data = cap_price;
                default: tx.tx_data = HEADER ^ {side, seq} ^ cap_price;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 2'd0;
            seq        <= 7'd0;
            cd_cnt     <= 8'd0;
            position   <= 8'sd0;
            drop_count <= 8'd0;
        end else begin
            if (drop_evt)
                drop_count <= sat_inc(drop_count);
            case (state)
                ST_IDLE: if (take_buy || take_sell) idx <= 2'd0;
                ST_SEND: begin
                    if (tx.tx_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            position <= side ? position - 8'sd1 : position + 8'sd1;
                            seq      <= seq + 7'd1;
                            cd_cnt   <= CD_LOAD;
                        end
                    end
                end
                ST_COOL: cd_cnt <= cd_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    // Side and price are frozen at acceptance so input churn during SEND cannot leak in.
    always_ff @(posedge clk) begin
        if (take_buy || take_sell) begin
            side      <= take_sell;
            cap_price <= price;
        end
    end

endmodule

// File: tb/tb_order_packetizer.sv
// Directed bench for order_packetizer: per-cycle vector table plus stall and async-reset sequences.
module tb_order_packetizer;

    logic clk = 1'b0;
    logic rst;
    logic buy_signal;
    logic sell_signal;
    logic [7:0] price;
    logic signed [7:0] position;
    logic busy;
    logic [7:0] drop_count;

    order_packetizer_if txif ();

    order_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .buy_signal (buy_signal),
        .sell_signal(sell_signal),
        .price      (price),
        .tx         (txif.master),
        .position   (position),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       buy;
        logic       sell;
        logic [7:0] price;
        logic       ready;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [7:0] epos;
        logic       eb;
        logic [7:0] edrop;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic void add_row(logic b, logic s, logic [7:0] p, logic r, logic ev,
                                    logic [7:0] ed, logic el, logic [7:0] epos, logic eb,
                                    logic [7:0] edrop);
        vec_t v;
        v.buy = b; v.sell = s; v.price = p; v.ready = r;
        v.ev = ev; v.ed = ed; v.el = el; v.epos = epos; v.eb = eb; v.edrop = edrop;
        vecs.push_back(v);
    endfunction

    // One full packet at tx_ready=1, followed by its 8-cycle cooldown and the first IDLE cycle.
    function automatic void add_packet(logic is_sell, logic [7:0] p, logic [6:0] sq,
                                       int pos_before, logic [7:0] drop);
        logic [7:0] b1;
        logic [7:0] pb;
        logic [7:0] pa;
        b1 = {is_sell, sq};
        pb = 8'(pos_before);
        pa = is_sell ? 8'(pos_before - 1) : 8'(pos_before + 1);
        add_row(!is_sell, is_sell, p, 1'b1, 1'b1, 8'hA5, 1'b0, pb, 1'b1, drop);
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, b1, 1'b0, pb, 1'b1, drop);
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, p, 1'b0, pb, 1'b1, drop);
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5 ^ b1 ^ p, 1'b1, pb, 1'b1, drop);
        for (int k = 0; k < 8; k++)
            add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, pa, 1'b1, drop);
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, pa, 1'b0, drop);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic ev, input logic [7:0] ed,
                            input logic el, input logic [7:0] epos, input logic eb,
                            input logic [7:0] edrop);
        chk({name, "_valid"}, {7'd0, txif.tx_valid}, {7'd0, ev});
        chk({name, "_data"},  txif.tx_data, ed);
        chk({name, "_last"},  {7'd0, txif.tx_last}, {7'd0, el});
        chk({name, "_pos"},   position, epos);
        chk({name, "_busy"},  {7'd0, busy}, {7'd0, eb});
        chk({name, "_drop"},  drop_count, edrop);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        buy_signal = 1'b0;
        sell_signal = 1'b0;
        price = 8'h00;
        txif.tx_ready = 1'b1;

        add_packet(1'b0, 8'h37, 7'd0, 0, 8'd0);
        add_packet(1'b0, 8'h40, 7'd1, 1, 8'd0);
        add_packet(1'b1, 8'h10, 7'd2, 2, 8'd0);
        for (int k = 1; k <= 3; k++)
            add_row(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0, 8'(k));
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0, 8'd3);
        add_packet(1'b0, 8'h21, 7'd3, 1, 8'd3);
        add_packet(1'b0, 8'h22, 7'd4, 2, 8'd3);
        add_packet(1'b0, 8'h23, 7'd5, 3, 8'd3);
        add_row(1'b1, 1'b0, 8'h24, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4, 1'b0, 8'd4);
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4, 1'b0, 8'd4);
        add_packet(1'b1, 8'h30, 7'd6, 4, 8'd4);

        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            buy_signal    = vecs[i].buy;
            sell_signal   = vecs[i].sell;
            price         = vecs[i].price;
            txif.tx_ready = vecs[i].ready;
            step();
            chk_outs($sformatf("row%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el,
                     vecs[i].epos, vecs[i].eb, vecs[i].edrop);
        end

        // Stall on byte1 while price churns and buys are requested.
        buy_signal = 1'b1; price = 8'h55; txif.tx_ready = 1'b1;
        step();
        chk("stall_b0", txif.tx_data, 8'hA5);
        buy_signal = 1'b0;
        step();
        chk("stall_b1", txif.tx_data, 8'h07);
        txif.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            price = 8'($urandom);
            buy_signal = (i % 2 == 0);
            step();
            chk($sformatf("stall%0d_data", i), txif.tx_data, 8'h07);
            chk($sformatf("stall%0d_valid", i), {7'd0, txif.tx_valid}, 8'd1);
        end
        chk("stall_drop", drop_count, 8'd9);
        buy_signal = 1'b0; txif.tx_ready = 1'b1;
        step();
        chk("stall_b2", txif.tx_data, 8'h55);
        step();
        chk("stall_b3", txif.tx_data, 8'hF7);
        chk("stall_last", {7'd0, txif.tx_last}, 8'd1);
        step();
        chk_outs("stall_done", 1'b0, 8'h00, 1'b0, 8'd4, 1'b1, 8'd9);
        repeat (8) step();
        chk("stall_idle", {7'd0, busy}, 8'd0);

        // Asynchronous reset after byte1 of a sell has been accepted.
        sell_signal = 1'b1; price = 8'h22;
        step();
        sell_signal = 1'b0;
        step();
        step();
        chk("pre_rst_b2", txif.tx_data, 8'h22);
        #2 rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'd0);
        #2 rst = 1'b0;
        step();
        chk("post_rst_quiet", {7'd0, txif.tx_valid}, 8'd0);
        buy_signal = 1'b1; price = 8'h11;
        step();
        chk("rst_pkt_b0", txif.tx_data, 8'hA5);
        buy_signal = 1'b0;
        step();
        chk("rst_pkt_b1", txif.tx_data, 8'h00);
        step();
        chk("rst_pkt_b2", txif.tx_data, 8'h11);
        step();
        chk("rst_pkt_b3", txif.tx_data, 8'hB4);
        step();
        chk_outs("rst_pkt_done", 1'b0, 8'h00, 1'b0, 8'd1, 1'b1, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
